// File: rtl/rip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rip_mem_arbiter_if
//
// Purpose:
//   Bundles the three handshake groups around the memory arbiter: the IF
//   fetch requester, the MA load/store requester and the single-port memory.
//
// Parameters:
//   ADDR_W  address width shared by both requesters and the memory port
//
// Signals (named as seen from the arbiter):
//   if_req/if_addr/if_kill              fetch request, address, flush kill
//   if_gnt/if_rvalid/if_rdata           fetch accept, response valid, data
//   ma_req/ma_we/ma_be/ma_addr/ma_wdata data request and payload
//   ma_gnt/ma_rvalid/ma_rdata           data accept, response valid, data
//   mem_req/mem_we/mem_be/mem_addr/
//   mem_wdata                           request towards the RAM
//   mem_gnt/mem_rvalid/mem_rdata        RAM accept and response
//
// Modports:
//   slave   the arbiter itself
//   master  the surrounding pipeline + RAM model driving the arbiter
// ---------------------------------------------------------------------------
interface rip_mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              ma_req;
  logic              ma_we;
  logic [3:0]        ma_be;
  logic [ADDR_W-1:0] ma_addr;
  logic [31:0]       ma_wdata;
  logic              ma_gnt;
  logic              ma_rvalid;
  logic [31:0]       ma_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_gnt, if_rvalid, if_rdata,
    input  ma_req, ma_we, ma_be, ma_addr, ma_wdata,
    output ma_gnt, ma_rvalid, ma_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_gnt, if_rvalid, if_rdata,
    output ma_req, ma_we, ma_be, ma_addr, ma_wdata,
    input  ma_gnt, ma_rvalid, ma_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/rip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rip_mem_arbiter
//
// Purpose:
//   Shares one single-port memory between the IF fetch requester and the MA
//   load/store requester. MA has fixed priority, but after MA_STREAK_MAX
//   consecutive MA grants while IF is waiting, IF wins the next contended
//   arbitration. Only one transaction is outstanding at a time. A kill from
//   the pipeline (jump flush) makes the arbiter swallow the pending fetch
//   response instead of presenting it to IF.
//
// Parameters:
//   ADDR_W         address width of both requesters and the memory port
//   MA_STREAK_MAX  max consecutive MA grants while IF waits (1..15)
//
// Ports:
//   clk                single clock, posedge
//   rst                synchronous active-high reset
//   bus                rip_mem_arbiter_if.slave: IF, MA and memory handshakes
//   perf_conflict_cnt  IDLE cycles with both requesters asking
//   perf_kill_cnt      fetch responses dropped because of a kill
//
// Configuration:
//   RIP_ARB_PERF_EN    when defined the two perf counters are implemented;
//                      otherwise both ports read constant zero and no counter
//                      flops exist. Arbitration behaviour is identical.
// ---------------------------------------------------------------------------
module rip_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int MA_STREAK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rip_mem_arbiter_if.slave     bus,
  output logic [31:0]          perf_conflict_cnt,
  output logic [31:0]          perf_kill_cnt
);

  localparam logic [3:0]        STREAK_MAX = 4'(MA_STREAK_MAX);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_MA
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       kill_pend_q, kill_pend_d;
  logic       ma_store_q, ma_store_d;
  logic       ma_owner;

  // State register. Reset wins over everything, so a transaction in flight
  // is abandoned and any late response will arrive while IDLE and be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      kill_pend_q <= 1'b0;
      ma_store_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_pend_q <= kill_pend_d;
      ma_store_q  <= ma_store_d;
    end
  end

  // Next-state and output decode. All outputs are forced low while rst is
  // high so the memory never accepts a request the arbiter is about to
  // forget. In IDLE the memory request is a combinational view of the
  // winning requester; in the WAIT states requests are held off and the
  // memory response is steered back to the owner.
  always_comb begin
    state_d        = state_q;
    streak_d       = streak_q;
    kill_pend_d    = kill_pend_q;
    ma_store_d     = ma_store_q;
    ma_owner       = 1'b0;

    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'h0;
    bus.mem_addr   = ADDR_ZERO;
    bus.mem_wdata  = 32'h0;
    bus.if_gnt     = 1'b0;
    bus.if_rvalid  = 1'b0;
    bus.if_rdata   = 32'h0;
    bus.ma_gnt     = 1'b0;
    bus.ma_rvalid  = 1'b0;
    bus.ma_rdata   = 32'h0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          // MA wins unless IF is also waiting and MA already had its streak.
          ma_owner    = bus.ma_req & (~bus.if_req | (streak_q < STREAK_MAX));
          bus.mem_req = bus.if_req | bus.ma_req;

          if (ma_owner) begin
            bus.mem_we    = bus.ma_we;
            bus.mem_be    = bus.ma_be;
            bus.mem_addr  = bus.ma_addr;
            bus.mem_wdata = bus.ma_wdata;
          end else if (bus.if_req) begin
            bus.mem_be    = 4'hF;
            bus.mem_addr  = bus.if_addr;
          end

          // The streak only means something while IF is actually waiting.
          if (!bus.if_req) begin
            streak_d = '0;
          end

          if (bus.mem_req && bus.mem_gnt) begin
            if (ma_owner) begin
              bus.ma_gnt = 1'b1;
              ma_store_d = bus.ma_we;
              state_d    = WAIT_MA;
              if (bus.if_req && (streak_q < STREAK_MAX)) begin
                streak_d = streak_q + 4'd1;
              end
            end else begin
              // A kill arriving with the grant still lets the grant happen;
              // the response is swallowed later.
              bus.if_gnt  = 1'b1;
              streak_d    = '0;
              kill_pend_d = bus.if_kill;
              state_d     = WAIT_IF;
            end
          end
        end

        WAIT_IF: begin
          if (bus.mem_rvalid) begin
            state_d     = IDLE;
            kill_pend_d = 1'b0;
            if (!(bus.if_kill || kill_pend_q)) begin
              bus.if_rvalid = 1'b1;
              bus.if_rdata  = bus.mem_rdata;
            end
          end else if (bus.if_kill) begin
            kill_pend_d = 1'b1;
          end
        end

        WAIT_MA: begin
          if (bus.mem_rvalid) begin
            state_d       = IDLE;
            bus.ma_rvalid = 1'b1;
            bus.ma_rdata  = ma_store_q ? 32'h0 : bus.mem_rdata;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef RIP_ARB_PERF_EN
  logic        conflict_evt;
  logic        kill_evt;
  logic [31:0] conflict_cnt_q;
  logic [31:0] kill_cnt_q;

  // Contention is only counted where arbitration happens (IDLE); a dropped
  // fetch is the WAIT_IF response cycle with a live or remembered kill.
  assign conflict_evt = ~rst & (state_q == IDLE) & bus.if_req & bus.ma_req;
  assign kill_evt     = ~rst & (state_q == WAIT_IF) & bus.mem_rvalid &
                        (bus.if_kill | kill_pend_q);

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= 32'h0;
      kill_cnt_q     <= 32'h0;
    end else begin
      if (conflict_evt) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
      if (kill_evt) begin
        kill_cnt_q <= kill_cnt_q + 32'd1;
      end
    end
  end

  assign perf_conflict_cnt = conflict_cnt_q;
  assign perf_kill_cnt     = kill_cnt_q;
`else
  assign perf_conflict_cnt = 32'h0;
  assign perf_kill_cnt     = 32'h0;
`endif

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rip_mem_arbiter
//
// Directed bench for rip_mem_arbiter. Stimulus drives the requesters and
// the memory side cycle by cycle and pushes the grant/response events it
// expects (kind, cycle, payload) into a queue; a forked monitor pops that
// queue whenever the DUT raises a gnt or rvalid. Point checks cover reset,
// hold-off, stability and perf counters.
// ---------------------------------------------------------------------------
module tb_rip_mem_arbiter;

  localparam int ADDR_W = 32;

`ifdef RIP_ARB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  localparam logic [36:0] IF_FIELDS  = {1'b0, 4'hF, 32'h0};
  localparam logic [36:0] NO_FIELDS  = 37'h0;

  typedef enum logic [1:0] {
    EV_IF_GNT,
    EV_MA_GNT,
    EV_IF_RV,
    EV_MA_RV
  } evKind_t;

  typedef struct {
    evKind_t     kind;
    int          cyc;
    logic [31:0] d0;
    logic [36:0] d1;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_kill_cnt;

  evt_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;
  int   cyc = 0;

  rip_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  rip_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .MA_STREAK_MAX(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .perf_conflict_cnt(perf_conflict_cnt),
    .perf_kill_cnt    (perf_kill_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of stimulus, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectEvt(input evKind_t k, input logic [31:0] d0, input logic [36:0] d1);
    evt_t e;
    e.kind = k;
    e.cyc  = cyc;
    e.d0   = d0;
    e.d1   = d1;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic checkEvt(input evKind_t k, input logic [31:0] d0, input logic [36:0] d1);
    evt_t e;
    testCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL unexpected_event: got kind=%0d cyc=%0d d0=%h d1=%h, want no event", k, cyc, d0, d1);
    end else begin
      e = expQ.pop_front();
      if (e.kind !== k || e.cyc != cyc || e.d0 !== d0 || e.d1 !== d1) begin
        failCount++;
        $display("[TB] FAIL event: got kind=%0d cyc=%0d d0=%h d1=%h, want kind=%0d cyc=%0d d0=%h d1=%h",
                 k, cyc, d0, d1, e.kind, e.cyc, e.d0, e.d1);
      end
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.if_gnt)    checkEvt(EV_IF_GNT, bus.mem_addr, {bus.mem_we, bus.mem_be, bus.mem_wdata});
        if (bus.ma_gnt)    checkEvt(EV_MA_GNT, bus.mem_addr, {bus.mem_we, bus.mem_be, bus.mem_wdata});
        if (bus.if_rvalid) checkEvt(EV_IF_RV, bus.if_rdata, NO_FIELDS);
        if (bus.ma_rvalid) checkEvt(EV_MA_RV, bus.ma_rdata, NO_FIELDS);
      end
    end
  endtask

  // Drives one full cycle of inputs just after the posedge and lets the
  // combinational outputs settle before returning.
  task automatic applyStimulus(
    input logic        ifReq,
    input logic [31:0] ifAddr,
    input logic        ifKill,
    input logic        maReq,
    input logic        maWe,
    input logic [3:0]  maBe,
    input logic [31:0] maAddr,
    input logic [31:0] maWdata,
    input logic        memGnt,
    input logic        memRvalid,
    input logic [31:0] memRdata
  );
    @(posedge clk);
    #1;
    bus.if_req     = ifReq;
    bus.if_addr    = ifAddr;
    bus.if_kill    = ifKill;
    bus.ma_req     = maReq;
    bus.ma_we      = maWe;
    bus.ma_be      = maBe;
    bus.ma_addr    = maAddr;
    bus.ma_wdata   = maWdata;
    bus.mem_gnt    = memGnt;
    bus.mem_rvalid = memRvalid;
    bus.mem_rdata  = memRdata;
    #1;
  endtask

  task automatic idleCycle(input logic memRvalid, input logic [31:0] memRdata);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, memRvalid, memRdata);
  endtask

  initial begin
    int maIdx;
    logic [5:0] maWins;
    logic [31:0] maA;

    rst            = 1'b1;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.if_kill    = 1'b0;
    bus.ma_req     = 1'b0;
    bus.ma_we      = 1'b0;
    bus.ma_be      = 4'h0;
    bus.ma_addr    = '0;
    bus.ma_wdata   = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, with junk on mem_rdata that must not leak out.
    idleCycle(1'b0, 32'h55);
    checkOutput("rst_mem_req",   32'(bus.mem_req),   32'h0);
    checkOutput("rst_mem_addr",  bus.mem_addr,       32'h0);
    checkOutput("rst_mem_be",    32'(bus.mem_be),    32'h0);
    checkOutput("rst_if_gnt",    32'(bus.if_gnt),    32'h0);
    checkOutput("rst_ma_gnt",    32'(bus.ma_gnt),    32'h0);
    checkOutput("rst_if_rdata",  bus.if_rdata,       32'h0);
    checkOutput("rst_ma_rdata",  bus.ma_rdata,       32'h0);
    checkOutput("rst_perf_conf", perf_conflict_cnt,  32'h0);
    checkOutput("rst_perf_kill", perf_kill_cnt,      32'h0);

    // 1: IF-only fetch, response one cycle after grant.
    applyStimulus(1'b1, 32'h8000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'h8000, IF_FIELDS);
    checkOutput("t1_mem_req", 32'(bus.mem_req), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h13);
    expectEvt(EV_IF_RV, 32'h13, NO_FIELDS);
    checkOutput("t1_ma_rvalid", 32'(bus.ma_rvalid), 32'h0);
    // Stray rvalid in IDLE must be ignored.
    idleCycle(1'b1, 32'h77);
    checkOutput("idle_rvalid_if", 32'(bus.if_rvalid), 32'h0);
    checkOutput("idle_rvalid_ma", 32'(bus.ma_rvalid), 32'h0);

    // 2: simultaneous requests, MA store wins, IF granted right after ack.
    applyStimulus(1'b1, 32'h8004, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hA5A51234, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_MA_GNT, 32'h100, {1'b1, 4'b0011, 32'hA5A51234});
    checkOutput("t2_mem_we", 32'(bus.mem_we), 32'h1);
    checkOutput("t2_mem_be", 32'(bus.mem_be), 32'h3);
    applyStimulus(1'b1, 32'h8004, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
    expectEvt(EV_MA_RV, 32'h0, NO_FIELDS);
    checkOutput("t2_wait_mem_req", 32'(bus.mem_req), 32'h0);
    applyStimulus(1'b1, 32'h8004, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'h8004, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h93);
    expectEvt(EV_IF_RV, 32'h93, NO_FIELDS);
    idleCycle(1'b0, 32'h0);

    // 3: continuous contention; 4 MA grants, 1 IF grant, then MA again.
    maWins = 6'b101111;
    maIdx  = 0;
    for (int i = 0; i < 6; i++) begin
      maA = 32'(32'h200 + 4 * maIdx);
      applyStimulus(1'b1, 32'h8008, 1'b0, 1'b1, 1'b0, 4'hF, maA, 32'h0, 1'b1, 1'b0, 32'h0);
      if (maWins[i]) begin
        expectEvt(EV_MA_GNT, maA, {1'b0, 4'hF, 32'h0});
        maIdx++;
      end else begin
        expectEvt(EV_IF_GNT, 32'h8008, IF_FIELDS);
      end
      maA = 32'(32'h200 + 4 * maIdx);
      applyStimulus(1'b1, 32'h8008, 1'b0, 1'b1, 1'b0, 4'hF, maA, 32'h0, 1'b1, 1'b1, 32'(32'h1000 + i));
      if (maWins[i]) expectEvt(EV_MA_RV, 32'(32'h1000 + i), NO_FIELDS);
      else           expectEvt(EV_IF_RV, 32'(32'h1000 + i), NO_FIELDS);
    end
    idleCycle(1'b0, 32'h0);
    checkOutput("t3_perf_conflict", perf_conflict_cnt, PERF_ON ? 32'd7 : 32'd0);

    // 6: memory stalls for 5 cycles; request and address must hold.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h9000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("t6_mem_req",  32'(bus.mem_req), 32'h1);
      checkOutput("t6_mem_addr", bus.mem_addr,     32'h9000);
    end
    applyStimulus(1'b1, 32'h9000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'h9000, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2222);
    expectEvt(EV_IF_RV, 32'h2222, NO_FIELDS);
    idleCycle(1'b0, 32'h0);

    // 4: kill pulsed in WAIT_IF before the response arrives.
    applyStimulus(1'b1, 32'hA000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'hA000, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("t4_killed_rvalid", 32'(bus.if_rvalid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_MA_GNT, 32'h300, {1'b0, 4'hF, 32'h0});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3333);
    expectEvt(EV_MA_RV, 32'h3333, NO_FIELDS);
    idleCycle(1'b0, 32'h0);
    checkOutput("t4_perf_kill_1", perf_kill_cnt, PERF_ON ? 32'd1 : 32'd0);

    // Kill together with the grant, then kill coincident with the response.
    applyStimulus(1'b1, 32'hA004, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'hA004, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("kill_at_gnt_rvalid", 32'(bus.if_rvalid), 32'h0);
    applyStimulus(1'b1, 32'hA008, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'hA008, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("kill_at_rsp_rvalid", 32'(bus.if_rvalid), 32'h0);

    // Kill in WAIT_MA and in idle IDLE has no effect on later traffic.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_MA_GNT, 32'h304, {1'b0, 4'hF, 32'h0});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555);
    expectEvt(EV_MA_RV, 32'h5555, NO_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hA00C, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'hA00C, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h6666);
    expectEvt(EV_IF_RV, 32'h6666, NO_FIELDS);
    idleCycle(1'b0, 32'h0);
    checkOutput("perf_kill_3", perf_kill_cnt, PERF_ON ? 32'd3 : 32'd0);

    // 5: reset during WAIT_MA, stale rvalid afterwards is dropped.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_MA_GNT, 32'h400, {1'b0, 4'hF, 32'h0});
    idleCycle(1'b0, 32'h0);
    rst = 1'b1;
    idleCycle(1'b1, 32'hBAD0);
    rst = 1'b0;
    #1;
    checkOutput("t5_ma_rvalid",  32'(bus.ma_rvalid), 32'h0);
    checkOutput("t5_ma_rdata",   bus.ma_rdata,       32'h0);
    checkOutput("t5_mem_req",    32'(bus.mem_req),   32'h0);
    checkOutput("t5_perf_conf",  perf_conflict_cnt,  32'h0);
    checkOutput("t5_perf_kill",  perf_kill_cnt,      32'h0);
    applyStimulus(1'b1, 32'hB000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    expectEvt(EV_IF_GNT, 32'hB000, IF_FIELDS);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4444);
    expectEvt(EV_IF_RV, 32'h4444, NO_FIELDS);
    idleCycle(1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
